// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream_mux block.
// Combinational only: no latency or backpressure of its own.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Channel index width; at least one bit so a 1-channel build still has a legal vector.
  function automatic int calc_sel_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Producer-side and consumer-side handshake bundle of stream_mux, plus its control inputs.
// Wires only: no latency; ready/valid semantics are defined by the mux.
interface stream_mux_if
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4
) ();

  localparam int SEL_W = calc_sel_w(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  mux_mode_e             mode;
  logic [SEL_W-1:0]      select;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester strictly after ptr, wrapping modulo N_CH.
// Purely combinational; the pointer register belongs to the caller.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = calc_sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    // Offset 1..N_CH: the last-served channel is visited last, giving it lowest priority.
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(ptr) + k) % N_CH;
      if (!any_gnt && req[c]) begin
        gnt[c]  = 1'b1;
        gnt_idx = SEL_W'(c);
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel stream multiplexer (fixed select or round-robin) with a registered output.
// 1-cycle latency, full throughput; a stalled output register drops every in_ready.
module stream_mux
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  stream_mux_if.slave bus
);

  localparam int SEL_W = calc_sel_w(N_CH);

  logic [SEL_W-1:0] rr_ptr;
  logic             load_en;

  logic [N_CH-1:0]  sel_gnt;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_any;

  logic [N_CH-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;

  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any_grant;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !bus.out_valid || bus.out_ready;

  // Out-of-range select values never match a channel, so they simply produce no grant.
  always_comb begin
    sel_gnt = '0;
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.select == SEL_W'(i) && bus.in_valid[i]) begin
        sel_gnt[i] = 1'b1;
        sel_idx    = SEL_W'(i);
        sel_any    = 1'b1;
      end
    end
  end

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  always_comb begin
    grant      = (bus.mode == MODE_RR) ? rr_gnt : sel_gnt;
    grant_idx  = (bus.mode == MODE_RR) ? rr_idx : sel_idx;
    any_grant  = (bus.mode == MODE_RR) ? rr_any : sel_any;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready = grant & {N_CH{load_en && rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr_ptr        <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (any_grant) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_ch    <= grant_idx;
        if (bus.mode == MODE_RR) rr_ptr <= grant_idx;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

  a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_ch)));

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: directed scenarios plus randomized traffic against a behavioural model.
module tb_stream_mux;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_if #(.N_CH(N), .WIDTH(W)) bus ();

  stream_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the output register contents and the last RR winner.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_ch;
  int         m_ptr;

  function automatic logic [W-1:0] chan(input int c);
    return bus.in_data[c*W +: W];
  endfunction

  function automatic int exp_grant();
    if (bus.mode == MODE_SEL) begin
      if (int'(bus.select) < N && bus.in_valid[int'(bus.select)]) return int'(bus.select);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c = (m_ptr + k) % N;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    int g = exp_grant();
    if (rst_n && (!m_valid || bus.out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    int g;
    bit le, rs;
    logic [W-1:0] d;
    mux_mode_e md;
    g  = exp_grant();
    le = !m_valid || bus.out_ready;
    rs = rst_n;
    md = bus.mode;
    d  = (g >= 0) ? chan(g) : '0;
    @(posedge clk);
    if (!rs) begin
      m_valid = 0; m_data = '0; m_ch = 0; m_ptr = N - 1;
    end else if (le) begin
      if (g >= 0) begin
        m_valid = 1; m_data = d; m_ch = g;
        if (md == MODE_RR) m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mode = MODE_RR;
    bus.select = '0;
    bus.out_ready = 1'b1;
    bus.in_valid = '1;
    bus.in_data = 16'hFEDC;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (bus.in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
      end
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 4'b0000 || bus.out_ch !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_out: valid=%b data=%b ch=%0d want 0/0000/0", bus.out_valid, bus.out_data, bus.out_ch);
      end
    end
  endtask

  task automatic test_sel_sweep();
    logic [N-1:0] oh;
    rst_n = 1'b1;
    bus.mode = MODE_SEL;
    bus.in_valid = '1;
    bus.out_ready = 1'b1;
    for (int s = 0; s < N; s++) begin
      bus.select = 2'(s);
      oh = 4'b0001 << s;
      #1;
      n_tests++;
      if (bus.in_ready !== oh) begin
        n_fail++; $display("FAIL sel_in_ready[%0d]: got %b want %b", s, bus.in_ready, oh);
      end
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(12 + s) || bus.out_ch !== 2'(s)) begin
        n_fail++;
        $display("FAIL sel_out[%0d]: valid=%b data=%b ch=%0d want 1/%b/%0d", s, bus.out_valid, bus.out_data, bus.out_ch, 4'(12 + s), s);
      end
    end
  endtask

  task automatic test_rr_fair();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mode = MODE_RR;
    bus.in_valid = '1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_tests++;
      if (bus.in_ready !== 4'(1 << (k % N))) begin
        n_fail++; $display("FAIL rr_fair_ready[%0d]: got %b want %b", k, bus.in_ready, 4'(1 << (k % N)));
      end
      tick();
      n_tests++;
      if (bus.out_ch !== 2'(k % N) || bus.out_data !== 4'(12 + k % N) || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_fair[%0d]: ch=%0d data=%b want %0d/%b", k, bus.out_ch, bus.out_data, k % N, 4'(12 + k % N));
      end
    end
  endtask

  task automatic test_rr_sparse();
    int e;
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 1 : 3;
      #1;
      n_tests++;
      if (bus.in_ready !== 4'(1 << e)) begin
        n_fail++; $display("FAIL rr_sparse_ready[%0d]: got %b want %b", k, bus.in_ready, 4'(1 << e));
      end
      tick();
      n_tests++;
      if (bus.out_ch !== 2'(e) || bus.out_data !== 4'(12 + e)) begin
        n_fail++; $display("FAIL rr_sparse[%0d]: ch=%0d data=%b want %0d", k, bus.out_ch, bus.out_data, e);
      end
    end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mode = MODE_RR;
    bus.in_valid = '1;
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_data !== 4'b1100 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: data=%b valid=%b want 1100/1", bus.out_data, bus.out_valid);
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (bus.in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.in_ready);
      end
      tick();
      n_tests++;
      if (bus.out_data !== 4'b1100 || bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: data=%b valid=%b want 1100/1", k, bus.out_data, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 0010", bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_data !== 4'b1101 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: data=%b want 1101", bus.out_data);
    end
    tick();
    n_tests++;
    if (bus.out_data !== 4'b1110) begin
      n_fail++; $display("FAIL bp_next: data=%b want 1110", bus.out_data);
    end
  endtask

  task automatic test_empty_reset();
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'b1110) begin
      n_fail++; $display("FAIL empty_drop: valid=%b data=%b want 0/1110", bus.out_valid, bus.out_data);
    end
    bus.in_valid = '1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3) begin
      n_fail++; $display("FAIL empty_refill: valid=%b ch=%0d want 1/3", bus.out_valid, bus.out_ch);
    end
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'b0000) begin
      n_fail++; $display("FAIL midreset: valid=%b data=%b want 0/0000", bus.out_valid, bus.out_data);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_ready: got %b want 0001", bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_ch !== 2'd0 || bus.out_data !== 4'b1100 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_first: ch=%0d data=%b want 0/1100", bus.out_ch, bus.out_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      bus.mode = mux_mode_e'($urandom_range(0, 1));
      bus.select = 2'($urandom_range(0, N - 1));
      bus.in_valid = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data = 16'($urandom);
      #1;
      er = exp_ready();
      n_tests++;
      if (bus.in_ready !== er) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", k, bus.in_ready, er);
      end
      tick();
      n_tests++;
      if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_ch !== 2'(m_ch)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: valid=%b data=%b ch=%0d want %b/%b/%0d", k, bus.out_valid, bus.out_data, bus.out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = N - 1;
    test_reset();
    test_sel_sweep();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_empty_reset();
    bus.in_data = 16'hFEDC;
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised N-channel multiplexer with a registered output and valid/ready handshaking on every channel.
- Supports two modes:
  - fixed external select, the classic mux behaviour;
  - round-robin arbitration among valid channels.
- Sits between several producer streams and one consumer. Output register gives one-cycle latency and full throughput.

Parameters:
- N_CH, 4: number of input channels, 2..16.
- WIDTH, 4: data width per channel.
- SEL_W, $clog2(N_CH): channel index width. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  N_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- mode  input  1  0 = MODE_SEL (use select), 1 = MODE_RR (round-robin).
- select  input  SEL_W  channel index used in MODE_SEL.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts data.

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - out_valid=0, out_data=0, out_ch=0;
  - rr_ptr=N_CH-1, so channel 0 has first priority after reset;
  - in_ready reads 0 while rst_n=0.
- Load enable: load_en = !out_valid || out_ready. A transfer on the output and a load may occur in the same cycle.
- Grant, combinational, one-hot or zero:
  - MODE_SEL:
    - grant[select]=1 iff in_valid[select];
    - select >= N_CH means no grant.
  - MODE_RR:
    - search channels rr_ptr+1, rr_ptr+2, ... with modulo-N_CH wrap;
    - first channel with in_valid set is granted.
- in_ready[i] = load_en && grant[i] && rst_n.
  - Non-granted channels see in_ready=0 and must hold their data.
- Input transfer on channel i when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= channel i data;
  - out_ch <= i;
  - out_valid <= 1;
  - in MODE_RR only, rr_ptr <= i.
- If load_en=1 and there is no grant, out_valid <= 0 on the next edge. out_data and out_ch keep their previous value.
- If out_valid && !out_ready:
  - out_data, out_ch and out_valid are held;
  - all in_ready are 0.
- Latency and throughput:
  - latency from input transfer to out_valid is 1 cycle;
  - sustained throughput is 1 word per cycle when out_ready=1.
- rr_ptr updates only on an RR transfer. It is not modified in MODE_SEL.
- Mode or select changes take effect on the next grant evaluation. A word already held in the output register is unaffected.
- Fairness: in MODE_RR with all channels continuously valid, grants cycle 0,1,...,N_CH-1,0,...
  - No channel waits more than N_CH-1 transfers.
- Reset asserted mid-stream: the held output word is discarded and out_valid=0 on the next edge. There is no partial-state recovery.
- No internal storage beyond the single output register. There are no overflow or underflow conditions.

Decomposition:
- Package mux_pkg:
  - mux_mode_e enum (MODE_SEL=1'b0, MODE_RR=1'b1);
  - function to compute SEL_W from N_CH.
- Sub-module rr_arbiter, parametrised by N_CH:
  - inputs: req[N_CH], ptr[SEL_W];
  - outputs: gnt[N_CH] one-hot, gnt_idx[SEL_W], any_gnt.
  - Purely combinational; rr_ptr register stays in stream_mux.
- MODE_SEL grant logic lives inline in stream_mux.

Test Plan:
- All tests use N_CH=4, WIDTH=4, with channel data ch0=1100, ch1=1101, ch2=1110, ch3=1111.
- Reset:
  - stimulus: hold rst_n=0 for 2 cycles with all in_valid=1;
  - response: out_valid=0, out_data=0000, in_ready=0000 throughout.
- MODE_SEL sweep:
  - stimulus: out_ready=1, all valid, select stepped 0,1,2,3, one per cycle;
  - response: one cycle after each step, out_data is 1100, 1101, 1110, 1111 and out_ch is 0..3;
  - in_ready is one-hot at the select position.
- MODE_RR fairness:
  - stimulus: all valid, out_ready=1, for 8 cycles after reset;
  - response: out_ch sequence is 0,1,2,3,0,1,2,3 and out_data matches each channel.
- MODE_RR sparse request:
  - stimulus: only ch1 and ch3 valid;
  - response: grants alternate 1,3,1,3;
  - response: in_ready[0] and in_ready[2] stay 0.
- Backpressure:
  - stimulus: out_ready=0 for 3 cycles after the first load;
  - response: out_data=1100 and out_valid=1 held, in_ready=0000;
  - stimulus: release out_ready;
  - response: next word 1101 appears one cycle later, with no word lost or duplicated.
- Empty and mid-stream reset:
  - stimulus: all in_valid=0 with out_ready=1;
  - response: out_valid drops one cycle later;
  - stimulus: rst_n=0 while out_valid=1 and out_ready=0;
  - response: out_valid=0 on the next edge, and the next RR grant goes to ch0.
